// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter/sequencer for the 4-source select mux: one-cycle arbitration, bursts capped at MAX_BURST beats.
// Optional macro ARB_STATS_EN adds the xfer_cnt completed-beat counter port.
module mux4_rr_arbiter #(
    parameter int MAX_BURST = 4,
    parameter int BEAT_W    = 8,
    parameter int STAT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        req,
    output logic [3:0]        ack,
    output logic [1:0]        sel,
    output logic [3:0]        gnt,
    output logic              out_valid,
    input  logic              out_ready
`ifdef ARB_STATS_EN
    ,
    output logic [STAT_W-1:0] xfer_cnt
`endif
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BURST - 1);

    generate
        if (MAX_BURST < 1 || MAX_BURST > (2**BEAT_W) - 1 || STAT_W < 1) begin : g_bad_param
            $error("mux4_rr_arbiter: illegal parameter combination");
        end
    endgenerate

    state_t             state_reg, state_next;
    logic [3:0]         gnt_reg, gnt_next;
    logic [1:0]         sel_reg, sel_next;
    logic [1:0]         ptr_reg, ptr_next;
    logic [BEAT_W-1:0]  beat_reg, beat_next;

    logic [3:0]         rot_req;
    logic [1:0]         offset;
    logic [1:0]         winner;
    logic               xfer;

    // rot_req[k] is the request of the source k places after ptr, so bit 0 has top priority.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rot
            assign rot_req[gi] = req[ptr_reg + 2'(gi)];
        end
    endgenerate

    always_comb begin
        offset = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (rot_req[i]) begin
                offset = 2'(i);
            end
        end
        winner = ptr_reg + offset;
    end

    // In BUSY the owner index is sel_reg, which is frozen for the whole grant.
    always_comb begin
        out_valid = (state_reg == BUSY) && req[sel_reg];
        xfer      = out_valid && out_ready;
        ack       = xfer ? gnt_reg : 4'b0000;
    end

    always_comb begin
        state_next = state_reg;
        gnt_next   = gnt_reg;
        sel_next   = sel_reg;
        ptr_next   = ptr_reg;
        beat_next  = beat_reg;
        case (state_reg)
            IDLE: begin
                if (req != 4'b0000) begin
                    state_next = BUSY;
                    gnt_next   = 4'b0001 << winner;
                    sel_next   = winner;
                    beat_next  = '0;
                end
            end
            BUSY: begin
                if ((xfer && beat_reg == LAST_BEAT) || !req[sel_reg]) begin
                    state_next = IDLE;
                    gnt_next   = 4'b0000;
                    ptr_next   = sel_reg + 2'd1;
                end else if (xfer) begin
                    beat_next = beat_reg + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            gnt_reg   <= 4'b0000;
            sel_reg   <= 2'b00;
            ptr_reg   <= 2'b00;
            beat_reg  <= '0;
        end else begin
            state_reg <= state_next;
            gnt_reg   <= gnt_next;
            sel_reg   <= sel_next;
            ptr_reg   <= ptr_next;
            beat_reg  <= beat_next;
        end
    end

    assign gnt = gnt_reg;
    assign sel = sel_reg;

`ifdef ARB_STATS_EN
    logic [STAT_W-1:0] xfer_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_cnt_reg <= '0;
        end else if (xfer) begin
            xfer_cnt_reg <= xfer_cnt_reg + 1'b1;
        end
    end

    assign xfer_cnt = xfer_cnt_reg;
`else
    // Statistics counter not built.
`endif

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed vector table, corner-case sequences, random traffic vs a grant/burst model.
module tb_mux4_rr_arbiter;

    localparam int MAX_BURST = 4;
    localparam int BEAT_W    = 8;
    localparam int STAT_W    = 16;

    logic              clk;
    logic              rst;
    logic [3:0]        req;
    logic [3:0]        ack;
    logic [1:0]        sel;
    logic [3:0]        gnt;
    logic              out_valid;
    logic              out_ready;
`ifdef ARB_STATS_EN
    logic [STAT_W-1:0] xfer_cnt;
`endif

    mux4_rr_arbiter #(
        .MAX_BURST(MAX_BURST),
        .BEAT_W   (BEAT_W),
        .STAT_W   (STAT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .ack      (ack),
        .sel      (sel),
        .gnt      (gnt),
        .out_valid(out_valid),
        .out_ready(out_ready)
`ifdef ARB_STATS_EN
        ,
        .xfer_cnt (xfer_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: who owns the mux (-1 = nobody), where the next search starts, beats done in this grant.
    int          m_owner;
    int          m_ptr;
    int          m_beats;
    int          m_sel;
    int unsigned m_cnt;

    logic [3:0]  s_gnt;
    logic [1:0]  s_sel;
    logic        s_valid;
    logic [3:0]  s_ack;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_beats = 0;
        m_sel   = 0;
        m_cnt   = 0;
    endfunction

    function automatic void model_step();
        if (rst) begin
            model_reset();
        end else if (m_owner < 0) begin
            for (int k = 0; k < 4; k++) begin
                int idx;
                idx = (m_ptr + k) % 4;
                if (m_owner < 0 && req[idx]) begin
                    m_owner = idx;
                    m_sel   = idx;
                    m_beats = 0;
                end
            end
        end else if (req[m_owner] && out_ready) begin
            m_cnt++;
            m_beats++;
            if (m_beats == MAX_BURST) begin
                m_ptr   = (m_owner + 1) % 4;
                m_owner = -1;
            end
        end else if (!req[m_owner]) begin
            m_ptr   = (m_owner + 1) % 4;
            m_owner = -1;
        end
    endfunction

    task automatic drive(input logic r, input logic [3:0] q, input logic rd);
        @(negedge clk);
        rst       = r;
        req       = q;
        out_ready = rd;
        #1;
        s_gnt   = gnt;
        s_sel   = sel;
        s_valid = out_valid;
        s_ack   = ack;
        if (ack != 4'b0000) begin
            $display("beat: t=%0t gnt=%b sel=%0d ack=%b", $time, gnt, sel, ack);
        end
    endtask

    // One cycle checked against the model, then the model advances on the clock edge.
    task automatic cyc(input logic r, input logic [3:0] q, input logic rd);
        logic [3:0] e_gnt;
        logic       e_valid;
        drive(r, q, rd);
        e_gnt   = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
        e_valid = (m_owner >= 0) && req[m_owner];
        chk("gnt", 32'(s_gnt), 32'(e_gnt));
        chk("sel", 32'(s_sel), 32'(m_sel));
        chk("out_valid", 32'(s_valid), 32'(e_valid));
        chk("ack", 32'(s_ack), 32'((e_valid && out_ready) ? e_gnt : 4'b0000));
`ifdef ARB_STATS_EN
        chk("xfer_cnt", 32'(xfer_cnt), 32'(STAT_W'(m_cnt)));
`endif
        @(posedge clk);
        model_step();
    endtask

    task automatic do_reset();
        cyc(1'b1, 4'b0000, 1'b0);
        cyc(1'b1, 4'b0000, 1'b0);
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       rdy;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       valid;
        logic [3:0] ack;
    } vec_t;

    vec_t vecs[11];

    initial begin
        logic [1:0] grant_sels[$];
        logic [3:0] prev_gnt;
        logic [3:0] r_req;
        int         acks;

        vecs[0]  = '{1'b1, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 4'b0000};
        vecs[1]  = '{1'b0, 4'b0100, 1'b1, 4'b0000, 2'd0, 1'b0, 4'b0000};
        vecs[2]  = '{1'b0, 4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 4'b0100};
        vecs[3]  = '{1'b0, 4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 4'b0100};
        vecs[4]  = '{1'b0, 4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 4'b0100};
        vecs[5]  = '{1'b0, 4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 4'b0100};
        vecs[6]  = '{1'b0, 4'b0100, 1'b1, 4'b0000, 2'd2, 1'b0, 4'b0000};
        vecs[7]  = '{1'b0, 4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1, 4'b0100};
        vecs[8]  = '{1'b0, 4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 4'b0000};
        vecs[9]  = '{1'b0, 4'b0000, 1'b1, 4'b0100, 2'd2, 1'b0, 4'b0000};
        vecs[10] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 2'd2, 1'b0, 4'b0000};

        rst       = 1'b1;
        req       = 4'b0000;
        out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);

        // Directed table: reset, single-source burst, re-grant after idle, stall, drop.
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].rst, vecs[i].req, vecs[i].rdy);
            chk($sformatf("vec%0d_gnt", i), 32'(s_gnt), 32'(vecs[i].gnt));
            chk($sformatf("vec%0d_sel", i), 32'(s_sel), 32'(vecs[i].sel));
            chk($sformatf("vec%0d_valid", i), 32'(s_valid), 32'(vecs[i].valid));
            chk($sformatf("vec%0d_ack", i), 32'(s_ack), 32'(vecs[i].ack));
            @(posedge clk);
            model_step();
        end

        // Fairness: all sources requesting, grant order s,r,o,a,s.
        do_reset();
        prev_gnt = 4'b0000;
        for (int i = 0; i < 26; i++) begin
            cyc(1'b0, 4'b1111, 1'b1);
            if (prev_gnt == 4'b0000 && s_gnt != 4'b0000) grant_sels.push_back(s_sel);
            prev_gnt = s_gnt;
        end
        chk("fair_grants", 32'(grant_sels.size()), 32'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < grant_sels.size()) chk($sformatf("fair_sel%0d", i), 32'(grant_sels[i]), 32'(i % 4));
        end

        // Early drop: r releases after 2 beats, ptr=2 so a wins over s.
        do_reset();
        cyc(1'b0, 4'b0010, 1'b1);
        cyc(1'b0, 4'b0010, 1'b1);
        cyc(1'b0, 4'b0010, 1'b1);
        cyc(1'b0, 4'b1001, 1'b1);
        chk("drop_no_xfer", 32'(s_ack), 32'd0);
        cyc(1'b0, 4'b1001, 1'b1);
        chk("drop_idle", 32'(s_gnt), 32'd0);
        cyc(1'b0, 4'b1001, 1'b1);
        chk("drop_next_gnt", 32'(s_gnt), 32'b1000);

        // Stall: s owns, ready low for 10 cycles, then the full burst still completes.
        do_reset();
        cyc(1'b0, 4'b0001, 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b0, 4'b0001, 1'b0);
        chk("stall_valid", 32'(s_valid), 32'd1);
        chk("stall_sel", 32'(s_sel), 32'd0);
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 4'b0001, 1'b1);
            if (s_ack == 4'b0001) acks++;
        end
        chk("stall_acks", 32'(acks), 32'd4);
        cyc(1'b0, 4'b0001, 1'b1);
        chk("stall_release", 32'(s_gnt), 32'd0);

        // Reset mid-burst of a; afterwards s wins because ptr is back to 0.
        do_reset();
        cyc(1'b0, 4'b1000, 1'b1);
        cyc(1'b0, 4'b1000, 1'b1);
        cyc(1'b0, 4'b1000, 1'b1);
        cyc(1'b1, 4'b1000, 1'b1);
        cyc(1'b0, 4'b1111, 1'b1);
        chk("rst_mid_gnt", 32'(s_gnt), 32'd0);
        chk("rst_mid_valid", 32'(s_valid), 32'd0);
        cyc(1'b0, 4'b1111, 1'b1);
        chk("rst_mid_regrant", 32'(s_gnt), 32'b0001);

        // Random traffic against the model.
        r_req = 4'b0000;
        for (int i = 0; i < 800; i++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 7) == 0) r_req[b] = ~r_req[b];
            end
            cyc(($urandom_range(0, 99) == 0), r_req, ($urandom_range(0, 3) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
